// File: rtl/direction_deque.sv
// Circular deque of 2-bit maze directions: push/pop at the back, pop at the front, registered outputs.
// Optional sticky error flag on ignored ops is built when DIR_DEQUE_ERR_EN is defined.
module direction_deque #(
  parameter int unsigned  DEPTH = 256,
  parameter int unsigned  DW    = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop_back,
  input  logic          pop_front,
  output logic [DW-1:0] dout_back,
  output logic [DW-1:0] dout_front,
  output logic          front_vld,
  output logic          back_vld,
  output logic          is_empty,
  output logic          is_full,
  output logic [AW:0]   count
`ifdef DIR_DEQUE_ERR_EN
  ,
  output logic          err
`endif
);

  localparam logic [AW:0]   CntZero = '0;
  localparam logic [AW:0]   CntOne  = (AW+1)'(1);
  localparam logic [AW:0]   CntTwo  = (AW+1)'(2);
  localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW-1:0] tail_m1;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] dout_back_q, dout_back_d;
  logic [DW-1:0] dout_front_q, dout_front_d;
  logic          back_vld_q, back_vld_d;
  logic          front_vld_q, front_vld_d;
  logic          is_empty_q, is_full_q;
  logic          wr_en;
  logic          empty, full;
  logic          ignored;

  assign empty   = (count_q == CntZero);
  assign full    = (count_q == CntFull);
  assign tail_m1 = tail_q - PtrOne;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    dout_back_d  = dout_back_q;
    dout_front_d = dout_front_q;
    back_vld_d   = 1'b0;
    front_vld_d  = 1'b0;
    wr_en        = 1'b0;
    ignored      = 1'b0;

    if (push && pop_back) begin
      // Push consumed straight back out; storage untouched, so this is legal even when full/empty.
      dout_back_d = din;
      back_vld_d  = 1'b1;
      if (pop_front) begin
        if (empty) begin
          ignored = 1'b1;
        end else begin
          dout_front_d = mem_q[head_q];
          front_vld_d  = 1'b1;
          head_d       = head_q + PtrOne;
          count_d      = count_q - CntOne;
        end
      end
    end else if (push && pop_front) begin
      front_vld_d = 1'b1;
      if (empty) begin
        dout_front_d = din;
      end else begin
        // When full head==tail: the read sees the old entry, the write refills the freed slot.
        dout_front_d = mem_q[head_q];
        head_d       = head_q + PtrOne;
        wr_en        = 1'b1;
        tail_d       = tail_q + PtrOne;
      end
    end else if (pop_back && pop_front) begin
      if (empty) begin
        ignored = 1'b1;
      end else begin
        dout_front_d = mem_q[head_q];
        front_vld_d  = 1'b1;
        head_d       = head_q + PtrOne;
        if (count_q == CntOne) begin
          // Single entry: the front pop takes it and the back pop is dropped.
          ignored = 1'b1;
          count_d = CntZero;
        end else begin
          dout_back_d = mem_q[tail_m1];
          back_vld_d  = 1'b1;
          tail_d      = tail_m1;
          count_d     = count_q - CntTwo;
        end
      end
    end else if (push) begin
      if (full) begin
        ignored = 1'b1;
      end else begin
        wr_en   = 1'b1;
        tail_d  = tail_q + PtrOne;
        count_d = count_q + CntOne;
      end
    end else if (pop_back) begin
      if (empty) begin
        ignored = 1'b1;
      end else begin
        dout_back_d = mem_q[tail_m1];
        back_vld_d  = 1'b1;
        tail_d      = tail_m1;
        count_d     = count_q - CntOne;
      end
    end else if (pop_front) begin
      if (empty) begin
        ignored = 1'b1;
      end else begin
        dout_front_d = mem_q[head_q];
        front_vld_d  = 1'b1;
        head_d       = head_q + PtrOne;
        count_d      = count_q - CntOne;
      end
    end
  end

  // Storage is deliberately not reset; clr and Rst only drop the pointers.
  always_ff @(posedge Clk) begin
    if (wr_en && !clr && !Rst) begin
      mem_q[tail_q] <= din;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      dout_back_q  <= '0;
      dout_front_q <= '0;
      back_vld_q   <= 1'b0;
      front_vld_q  <= 1'b0;
      is_empty_q   <= 1'b1;
      is_full_q    <= 1'b0;
    end else if (clr) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      dout_back_q  <= '0;
      dout_front_q <= '0;
      back_vld_q   <= 1'b0;
      front_vld_q  <= 1'b0;
      is_empty_q   <= 1'b1;
      is_full_q    <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      dout_back_q  <= dout_back_d;
      dout_front_q <= dout_front_d;
      back_vld_q   <= back_vld_d;
      front_vld_q  <= front_vld_d;
      is_empty_q   <= (count_d == CntZero);
      is_full_q    <= (count_d == CntFull);
    end
  end

  assign dout_back  = dout_back_q;
  assign dout_front = dout_front_q;
  assign back_vld   = back_vld_q;
  assign front_vld  = front_vld_q;
  assign is_empty   = is_empty_q;
  assign is_full    = is_full_q;
  assign count      = count_q;

`ifdef DIR_DEQUE_ERR_EN
  logic err_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err_q <= 1'b0;
    end else if (clr) begin
      err_q <= 1'b0;
    end else if (ignored) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_ignored;
  assign unused_ignored = ignored;
`endif

endmodule

// File: tb/tb_direction_deque.sv
// Scoreboard bench for direction_deque: a queue model predicts pop data, flags and count per cycle.
// Checks err as well when DIR_DEQUE_ERR_EN is defined.
module tb_direction_deque;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          clr = 1'b0;
  logic          push = 1'b0;
  logic [1:0]    din = 2'b00;
  logic          pop_back = 1'b0;
  logic          pop_front = 1'b0;
  logic [1:0]    dout_back, dout_front;
  logic          front_vld, back_vld, is_empty, is_full;
  logic [AW:0]   count;
`ifdef DIR_DEQUE_ERR_EN
  logic          err;
`endif

  direction_deque #(.DEPTH(DEPTH), .DW(2)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .clr        (clr),
    .push       (push),
    .din        (din),
    .pop_back   (pop_back),
    .pop_front  (pop_front),
    .dout_back  (dout_back),
    .dout_front (dout_front),
    .front_vld  (front_vld),
    .back_vld   (back_vld),
    .is_empty   (is_empty),
    .is_full    (is_full),
`ifdef DIR_DEQUE_ERR_EN
    .err        (err),
`endif
    .count      (count)
  );

  always #5 Clk = ~Clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] model[$];
  logic [1:0] sb_back[$];
  logic [1:0] sb_front[$];
  logic       exp_bv, exp_fv, err_m;
  logic [1:0] e;

  task automatic model_clear();
    model.delete();
    sb_back.delete();
    sb_front.delete();
    exp_bv = 1'b0;
    exp_fv = 1'b0;
    err_m  = 1'b0;
  endtask

  // Drives one cycle of requests and records what the DUT must show after the edge.
  task automatic do_op(input logic p, input logic [1:0] d, input logic pb, input logic pf);
    int n;
    @(negedge Clk);
    push = p; din = d; pop_back = pb; pop_front = pf;
    n = model.size();
    exp_bv = 1'b0;
    exp_fv = 1'b0;
    if (p && pb) begin
      exp_bv = 1'b1;
      sb_back.push_back(d);
      if (pf) begin
        if (n > 0) begin exp_fv = 1'b1; sb_front.push_back(model.pop_front()); end
        else err_m = 1'b1;
      end
    end else if (p && pf) begin
      exp_fv = 1'b1;
      if (n == 0) sb_front.push_back(d);
      else begin sb_front.push_back(model.pop_front()); model.push_back(d); end
    end else if (pb && pf) begin
      if (n == 0) err_m = 1'b1;
      else begin
        exp_fv = 1'b1;
        sb_front.push_back(model.pop_front());
        if (n >= 2) begin exp_bv = 1'b1; sb_back.push_back(model.pop_back()); end
        else err_m = 1'b1;
      end
    end else if (p) begin
      if (n < DEPTH) model.push_back(d); else err_m = 1'b1;
    end else if (pb) begin
      if (n > 0) begin exp_bv = 1'b1; sb_back.push_back(model.pop_back()); end
      else err_m = 1'b1;
    end else if (pf) begin
      if (n > 0) begin exp_fv = 1'b1; sb_front.push_back(model.pop_front()); end
      else err_m = 1'b1;
    end
    @(posedge Clk);
    #1;
    push = 1'b0; pop_back = 1'b0; pop_front = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    model_clear();
    #1;
    vectors += 6;
    if (count !== '0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    if (is_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", is_empty); end
    if (is_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", is_full); end
    if (dout_back !== 2'b00 || dout_front !== 2'b00) begin
      miscompares++; $display("FAIL reset_dout got %b/%b want 00/00", dout_back, dout_front);
    end
    if (back_vld !== 1'b0 || front_vld !== 1'b0) begin
      miscompares++; $display("FAIL reset_vld got %b/%b want 0/0", back_vld, front_vld);
    end
`ifdef DIR_DEQUE_ERR_EN
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
`else
    if (is_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty2 got %b want 1", is_empty); end
`endif
  endtask

  task automatic test_push_pop_back();
    logic [1:0] seq [4];
    logic [1:0] want [4];
    seq  = '{2'b00, 2'b01, 2'b01, 2'b11};
    want = '{2'b11, 2'b01, 2'b01, 2'b00};
    foreach (seq[i]) do_op(1'b1, seq[i], 1'b0, 1'b0);
    vectors += 2;
    if (count !== (AW+1)'(4)) begin miscompares++; $display("FAIL lifo_count got %0d want 4", count); end
    if (is_empty !== 1'b0) begin miscompares++; $display("FAIL lifo_empty got %b want 0", is_empty); end
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, 2'b00, 1'b1, 1'b0);
      vectors += 2;
      if (back_vld !== exp_bv) begin
        miscompares++; $display("FAIL lifo_vld[%0d] got %b want %b", i, back_vld, exp_bv);
      end
      if (exp_bv) begin
        e = sb_back.pop_front();
        if (dout_back !== e || dout_back !== want[i]) begin
          miscompares++; $display("FAIL lifo_data[%0d] got %b want %b", i, dout_back, want[i]);
        end
      end
    end
    vectors++;
    if (is_empty !== 1'b1) begin miscompares++; $display("FAIL lifo_end_empty got %b want 1", is_empty); end
  endtask

  task automatic test_pop_front();
    logic [1:0] seq [3];
    seq = '{2'b00, 2'b01, 2'b10};
    foreach (seq[i]) do_op(1'b1, seq[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 2'b00, 1'b0, 1'b1);
      vectors += 2;
      if (front_vld !== 1'b1) begin miscompares++; $display("FAIL fifo_vld[%0d] got %b want 1", i, front_vld); end
      e = sb_front.pop_front();
      if (dout_front !== e || dout_front !== seq[i]) begin
        miscompares++; $display("FAIL fifo_data[%0d] got %b want %b", i, dout_front, seq[i]);
      end
    end
    vectors++;
    if (is_empty !== 1'b1) begin miscompares++; $display("FAIL fifo_end_empty got %b want 1", is_empty); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 2'(i * 3 + 1), 1'b0, 1'b0);
    vectors += 2;
    if (is_full !== 1'b1) begin miscompares++; $display("FAIL full_flag got %b want 1", is_full); end
    if (count !== (AW+1)'(DEPTH)) begin miscompares++; $display("FAIL full_count got %0d want %0d", count, DEPTH); end
    do_op(1'b1, 2'b10, 1'b0, 1'b0);
    vectors += 2;
    if (count !== (AW+1)'(DEPTH)) begin miscompares++; $display("FAIL full_ignored got %0d want %0d", count, DEPTH); end
`ifdef DIR_DEQUE_ERR_EN
    if (err !== err_m) begin miscompares++; $display("FAIL full_err got %b want %b", err, err_m); end
`else
    if (is_full !== 1'b1) begin miscompares++; $display("FAIL full_hold got %b want 1", is_full); end
`endif
    for (int i = 0; i < DEPTH + 3; i++) begin
      do_op(1'b1, 2'(i), 1'b0, 1'b1);
      vectors += 3;
      if (front_vld !== 1'b1) begin miscompares++; $display("FAIL wrap_vld[%0d] got %b want 1", i, front_vld); end
      e = sb_front.pop_front();
      if (dout_front !== e) begin miscompares++; $display("FAIL wrap_data[%0d] got %b want %b", i, dout_front, e); end
      if (count !== (AW+1)'(DEPTH)) begin miscompares++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, count, DEPTH); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_op(1'b0, 2'b00, 1'b0, 1'b1);
      vectors++;
      e = sb_front.pop_front();
      if (dout_front !== e) begin miscompares++; $display("FAIL drain_data[%0d] got %b want %b", i, dout_front, e); end
    end
    vectors++;
    if (is_empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %b want 1", is_empty); end
  endtask

  task automatic test_bypass_empty();
    do_op(1'b1, 2'b11, 1'b1, 1'b0);
    vectors += 3;
    e = sb_back.pop_front();
    if (back_vld !== 1'b1) begin miscompares++; $display("FAIL byp_vld got %b want 1", back_vld); end
    if (dout_back !== e || dout_back !== 2'b11) begin miscompares++; $display("FAIL byp_data got %b want 11", dout_back); end
    if (count !== '0) begin miscompares++; $display("FAIL byp_count got %0d want 0", count); end
    do_op(1'b0, 2'b00, 1'b1, 1'b0);
    vectors += 2;
    if (back_vld !== 1'b0) begin miscompares++; $display("FAIL empty_pop_vld got %b want 0", back_vld); end
    if (dout_back !== 2'b11) begin miscompares++; $display("FAIL empty_pop_hold got %b want 11", dout_back); end
  endtask

  task automatic test_count_one();
    do_op(1'b1, 2'b01, 1'b0, 1'b0);
    do_op(1'b0, 2'b00, 1'b1, 1'b1);
    vectors += 4;
    e = sb_front.pop_front();
    if (front_vld !== 1'b1) begin miscompares++; $display("FAIL one_fvld got %b want 1", front_vld); end
    if (dout_front !== e || dout_front !== 2'b01) begin miscompares++; $display("FAIL one_data got %b want 01", dout_front); end
    if (back_vld !== 1'b0) begin miscompares++; $display("FAIL one_bvld got %b want 0", back_vld); end
    if (count !== '0) begin miscompares++; $display("FAIL one_count got %0d want 0", count); end
`ifdef DIR_DEQUE_ERR_EN
    vectors++;
    if (err !== err_m) begin miscompares++; $display("FAIL one_err got %b want %b", err, err_m); end
`endif
  endtask

  task automatic test_back_to_back();
    logic p, pb, pf;
    for (int i = 0; i < 300; i++) begin
      p  = ($urandom_range(0, 9) < 6);
      pb = ($urandom_range(0, 9) < 3);
      pf = ($urandom_range(0, 9) < 3);
      do_op(p, 2'($urandom_range(0, 3)), pb, pf);
      vectors += 5;
      if (back_vld !== exp_bv) begin miscompares++; $display("FAIL rnd_bvld[%0d] got %b want %b", i, back_vld, exp_bv); end
      if (front_vld !== exp_fv) begin miscompares++; $display("FAIL rnd_fvld[%0d] got %b want %b", i, front_vld, exp_fv); end
      if (count !== (AW+1)'(model.size())) begin
        miscompares++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, model.size());
      end
      if (is_empty !== (model.size() == 0)) begin miscompares++; $display("FAIL rnd_empty[%0d] got %b", i, is_empty); end
      if (is_full !== (model.size() == DEPTH)) begin miscompares++; $display("FAIL rnd_full[%0d] got %b", i, is_full); end
      if (exp_bv) begin
        vectors++;
        e = sb_back.pop_front();
        if (dout_back !== e) begin miscompares++; $display("FAIL rnd_bdata[%0d] got %b want %b", i, dout_back, e); end
      end
      if (exp_fv) begin
        vectors++;
        e = sb_front.pop_front();
        if (dout_front !== e) begin miscompares++; $display("FAIL rnd_fdata[%0d] got %b want %b", i, dout_front, e); end
      end
    end
  endtask

  task automatic test_clear();
    model_clear();
    do_op(1'b0, 2'b00, 1'b0, 1'b0);
    do_op(1'b1, 2'b10, 1'b0, 1'b0);
    do_op(1'b1, 2'b11, 1'b0, 1'b1);
    do_op(1'b1, 2'b01, 1'b0, 1'b0);
    do_op(1'b1, 2'b11, 1'b1, 1'b0);
    do_op(1'b0, 2'b00, 1'b1, 1'b1);
    do_op(1'b0, 2'b00, 1'b1, 1'b1);
    @(negedge Clk);
    clr = 1'b1; push = 1'b1; din = 2'b11; pop_front = 1'b1;
    @(posedge Clk);
    #1;
    clr = 1'b0; push = 1'b0; pop_front = 1'b0;
    model_clear();
    vectors += 4;
    if (count !== '0 || is_empty !== 1'b1) begin
      miscompares++; $display("FAIL clr_state got count %0d empty %b want 0/1", count, is_empty);
    end
    if (dout_back !== 2'b00 || dout_front !== 2'b00) begin
      miscompares++; $display("FAIL clr_dout got %b/%b want 00/00", dout_back, dout_front);
    end
    if (front_vld !== 1'b0 || back_vld !== 1'b0) begin
      miscompares++; $display("FAIL clr_vld got %b/%b want 0/0", front_vld, back_vld);
    end
`ifdef DIR_DEQUE_ERR_EN
    if (err !== 1'b0) begin miscompares++; $display("FAIL clr_err got %b want 0", err); end
`else
    if (is_full !== 1'b0) begin miscompares++; $display("FAIL clr_full got %b want 0", is_full); end
`endif
    do_op(1'b1, 2'b01, 1'b0, 1'b0);
    do_op(1'b1, 2'b10, 1'b0, 1'b0);
    do_op(1'b1, 2'b11, 1'b1, 1'b0);
    @(negedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    vectors += 3;
    if (count !== '0 || is_empty !== 1'b1) begin
      miscompares++; $display("FAIL arst_state got count %0d empty %b want 0/1", count, is_empty);
    end
    if (dout_back !== 2'b00) begin miscompares++; $display("FAIL arst_dout got %b want 00", dout_back); end
    if (back_vld !== 1'b0) begin miscompares++; $display("FAIL arst_vld got %b want 0", back_vld); end
    Rst = 1'b0;
    model_clear();
    do_op(1'b1, 2'b10, 1'b0, 1'b0);
    do_op(1'b0, 2'b00, 1'b0, 1'b1);
    vectors++;
    if (dout_front !== 2'b10) begin miscompares++; $display("FAIL post_rst_data got %b want 10", dout_front); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_push_pop_back();
    test_pop_front();
    test_full_wrap();
    test_bypass_empty();
    test_count_one();
    test_back_to_back();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
